// File: rtl/regfile_writeback.sv
// Write-side front end for the 8x16 register file: merges ALU results and load returns
// into one registered write port, tracks load-pending registers, and bypasses reads.
module regfile_writeback #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [15:0] alu_data,
  input  logic        ld_issue,
  input  logic [2:0]  ld_issue_rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_rd,
  input  logic [15:0] ld_data,
  output logic [7:0]  busy,
  output logic        err,
  output logic        rf_wen,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  input  logic [2:0]  byp_raddr1,
  input  logic [2:0]  byp_raddr2,
  input  logic [15:0] rf_rdata1,
  input  logic [15:0] rf_rdata2,
  output logic [15:0] byp_rdata1,
  output logic [15:0] byp_rdata2
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      busy_q, busy_d;
  logic            err_q, err_d;
  logic            rf_wen_q, rf_wen_d;
  logic [2:0]      rf_waddr_q, rf_waddr_d;
  logic [15:0]     rf_wdata_q, rf_wdata_d;

  logic            alu_win, fifo_empty, ld_keep, push, pop, ld_direct, viol;
  logic [7:0]      set_v, clr_v;
  entry_t          head;

  // Count is at most DEPTH (a power of two), so its MSB alone marks "full".
  assign ld_ready = !rst && !count_q[AW];

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    alu_win    = alu_valid && (alu_rd != 3'd0);
    fifo_empty = (count_q == '0);
    ld_keep    = ld_valid && ld_ready && (ld_rd != 3'd0);
    pop        = !alu_win && !fifo_empty;
    ld_direct  = !alu_win && fifo_empty && ld_keep;
    push       = ld_keep && !ld_direct;
    head       = mem_q[rd_ptr_q];

    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    clr_v      = '0;
    set_v      = '0;

    if (alu_win) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end else if (pop) begin
      rf_wen_d          = 1'b1;
      rf_waddr_d        = head.rd;
      rf_wdata_d        = head.data;
      clr_v[head.rd]    = 1'b1;
    end else if (ld_direct) begin
      rf_wen_d          = 1'b1;
      rf_waddr_d        = ld_rd;
      rf_wdata_d        = ld_data;
      clr_v[ld_rd]      = 1'b1;
    end

    if (ld_issue && (ld_issue_rd != 3'd0)) set_v[ld_issue_rd] = 1'b1;
    // Set is applied after clear so a same-cycle re-issue keeps the register busy.
    busy_d = ((busy_q & ~clr_v) | set_v) & 8'hFE;

    viol = (alu_win && busy_q[alu_rd])
        || (ld_keep && !busy_q[ld_rd])
        || (ld_issue && (ld_issue_rd != 3'd0) && busy_q[ld_issue_rd]);
    err_d = err_q | viol;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // NOTE: queue storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: ld_rd, data: ld_data};
  end

  assign busy     = busy_q;
  assign err      = err_q;
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  assign byp_rdata1 = (rf_wen_q && (rf_waddr_q == byp_raddr1) && (byp_raddr1 != 3'd0))
                      ? rf_wdata_q : rf_rdata1;
  assign byp_rdata2 = (rf_wen_q && (rf_waddr_q == byp_raddr2) && (byp_raddr2 != 3'd0))
                      ? rf_wdata_q : rf_rdata2;

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the 8×16-bit register file (r0 reads as zero, writes to r0 are ignored). It merges single-cycle ALU results with variable-latency load returns and drives the file's single write port (`wen`/`waddr`/`wdata`) from registered outputs. It keeps a busy scoreboard of registers awaiting a load, so decode can stall on them. It also supplies read-port bypass, so a value being written this cycle is visible to readers.

## Interface
Parameters:
- DEPTH, 2, load-return queue entries; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- alu_valid  in  1  ALU result valid; no backpressure.
- alu_rd  in  3  ALU destination register.
- alu_data  in  16  ALU result.
- ld_issue  in  1  a load to ld_issue_rd was issued this cycle.
- ld_issue_rd  in  3  destination of the issued load.
- ld_valid  in  1  load return valid.
- ld_ready  out  1  load return accepted when ld_valid && ld_ready.
- ld_rd  in  3  load return destination.
- ld_data  in  16  load return data.
- busy  out  8  scoreboard, one bit per register; bit 0 is constant 0.
- err  out  1  sticky protocol-violation flag.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  3  register-file write address (registered).
- rf_wdata  out  16  register-file write data (registered).
- byp_raddr1, byp_raddr2  in  3  register-file read addresses.
- rf_rdata1, rf_rdata2  in  16  raw register-file read data.
- byp_rdata1, byp_rdata2  out  16  bypassed read data (combinational).

## Operation
- **Queue.** FIFO of {rd, data}, DEPTH entries.
  - ld_ready = !rst && (count < DEPTH).
  - Accepted returns with ld_rd == 0 are discarded and not enqueued.
- **Arbitration**, once per cycle. The ALU has fixed priority.
  - If alu_valid && alu_rd != 0: load the output registers with {alu_rd, alu_data}.
  - Else if the FIFO is non-empty: pop the head and load it into the output registers.
  - Else if a load is accepted this cycle with ld_rd != 0: it bypasses the FIFO straight to the output registers.
  - Else: rf_wen ← 0.
  - An ALU result with rd == 0 is dropped and does not block the FIFO.
- **Push/pop.** Push and pop in the same cycle are legal; count is unchanged. A full FIFO never accepts, even when popping that cycle.
- **Scoreboard set.** ld_issue && ld_issue_rd != 0 sets busy[ld_issue_rd] at the next edge.
- **Scoreboard clear.** busy[r] clears at the edge where a load write to r is loaded into the output registers. If a set and a clear hit the same register in the same cycle, the set wins.
- **Hazard contract.** Decode must not issue a load to a busy register, and must not issue an ALU op writing a busy register.
- **err** sets (sticky until rst) on any of:
  - alu_valid && alu_rd != 0 && busy[alu_rd];
  - an accepted ld_valid with ld_rd != 0 && !busy[ld_rd];
  - ld_issue to an already-busy register.
  A violating write is still performed.
- **Bypass.** byp_rdataN = rf_wdata when rf_wen && rf_waddr == byp_raddrN && byp_raddrN != 0; otherwise rf_rdataN.

## Timing
- **Reset values:** rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, err=0, FIFO empty, ld_ready=0 while rst is high.
- **Reset mid-operation:** drops queued loads and all busy bits. The first cycle after rst deasserts has ld_ready=1.
- **ALU latency:** alu_valid at cycle N → rf_wen=1 during N+1; the register file updates at the end of N+1.
- **Load latency:** accepted at N with FIFO empty and no ALU win → rf_wen during N+1. Each ALU-win cycle adds one cycle of delay.
- **Write order:** load writes retire in acceptance order. An ALU result in cycle N is written before any load still queued in N.
- **Throughput:** at most one register-file write per cycle. Under continuous ALU traffic the queue fills and ld_ready drops the cycle after count reaches DEPTH.
- **Busy timing:** busy[r] is 1 from the cycle after issue up to and including the cycle before the load's rf_wen cycle. During the rf_wen cycle, the bypass supplies the data.

## Test plan
- **Reset then single ALU write:** alu_valid, rd=3, data=16'h1234 at N → rf_wen=1, waddr=3, wdata=1234 at N+1; byp_raddr1=3 in N+1 returns 1234; rf_wen=0 at N+2.
- **Load with scoreboard:** ld_issue rd=5 at N → busy[5]=1 at N+1. ld_valid rd=5, data=00AA at N+3 → rf_wen at N+4 with busy[5]=0; err=0.
- **ALU starving loads:** alu_valid every cycle for 6 cycles, 3 loads offered back-to-back:
  - the first 2 are accepted;
  - ld_ready=0 once full;
  - after the ALU stops, the loads write on consecutive cycles in order.
- **r0 handling:** ALU write rd=0 → no rf_wen; busy stays 8'h00; byp_raddr=0 returns rf_rdata; load rd=0 accepted but never written.
- **Violations:** ALU writes a busy register → err=1, write still happens, err holds until rst. An unexpected load return (register not busy) also sets err.
- **Reset with 2 queued loads:** rst for 1 cycle → no rf_wen afterwards, busy=0, ld_ready=1 the cycle after deassertion.
